// File: rtl/heartbeat_sseg_scan_if.sv
// Display-side bundle for the heartbeat scanner: digit codes and scan enable in,
// multiplexed anode/segment drive and debug slot out.
interface heartbeat_sseg_scan_if;
    logic       en;
    logic [1:0] digit0;
    logic [1:0] digit1;
    logic [1:0] digit2;
    logic [1:0] digit3;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] slot;

    modport master (output en, digit0, digit1, digit2, digit3,
                    input  an, seg, dp, slot);
    modport slave  (input  en, digit0, digit1, digit2, digit3,
                    output an, seg, dp, slot);
endinterface

// File: rtl/heartbeat_sseg_scan.sv
// Four-digit multiplexed seven-segment scanner for heartbeat bar codes, with
// per-frame snapshot of the digit codes and blanking at the start of each slot.
module heartbeat_sseg_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    heartbeat_sseg_scan_if.slave  bus
);
    localparam int             PW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]  PMAX   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]  PBLANK = PW'(BLANK_CYCLES);

    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [1:0]      slot_q, slot_d;
    logic [3:0][1:0] snap_q, snap_d;
    // an_q/seg_q hold active-high "lit" state; polarity is applied at the pins
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            wrap, blank;
    logic [6:0]      lit_seg;

    always_comb begin
        wrap   = (pcnt_q == PMAX);
        pcnt_d = pcnt_q;
        slot_d = slot_q;
        snap_d = snap_q;
        if (bus.en) begin
            pcnt_d = wrap ? '0 : pcnt_q + PW'(1);
            if (wrap) begin
                slot_d = slot_q + 2'd1;
                if (slot_q == 2'd3)
                    snap_d = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
            end
        end
    end

    always_comb begin
        unique case (snap_q[slot_q])
            2'b01:   lit_seg = 7'b0110000;  // e,f
            2'b10:   lit_seg = 7'b0000110;  // b,c
            2'b11:   lit_seg = 7'b0110110;  // b,c,e,f
            default: lit_seg = 7'b0000000;
        endcase
        blank = !bus.en || (pcnt_q < PBLANK);
        an_d  = blank ? 4'b0000 : (4'b0001 << slot_q);
        seg_d = blank ? 7'b0000000 : lit_seg;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcnt_q <= '0;
            slot_q <= 2'd0;
            snap_q <= '0;
            an_q   <= 4'b0000;
            seg_q  <= 7'b0000000;
        end else begin
            pcnt_q <= pcnt_d;
            slot_q <= slot_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign bus.an   = an_q  ^ {4{ACTIVE_LOW}};
    assign bus.seg  = seg_q ^ {7{ACTIVE_LOW}};
    assign bus.dp   = ACTIVE_LOW;
    assign bus.slot = slot_q;
endmodule
